vga_timing: RTL and testbench
=============================

// Module: vga_timing
//
// PURPOSE
// Raster timing generator for the 640x480@60 VGA path; sits directly upstream of the image
// generators (checkerboard, fractal) inside top. Free-running horizontal/vertical counters
// produce pixel coordinates, active-low hsync/vsync, a visible-area flag and line/frame strobes.
// SYNC_DELAY re-times sync/visible to match the latency of a pipelined image generator.
//
// PARAMETERS
// H_VISIBLE   640  active pixels per line
// H_FRONT     16   horizontal front porch (clocks)
// H_SYNC      96   hsync pulse width (clocks)
// H_BACK      48   horizontal back porch (clocks)
// V_VISIBLE   480  active lines per frame
// V_FRONT     10   vertical front porch (lines)
// V_SYNC      2    vsync pulse width (lines)
// V_BACK      33   vertical back porch (lines)
// SYNC_DELAY  0    extra register stages on hsync/vsync/visible (0..7)
//
// PORTS
// clk_25_175   in   1   pixel clock, 25.175 MHz
// rst          in   1   asynchronous, active-high reset
// x            out  10  current horizontal count, 0..H_TOTAL-1
// y            out  10  current vertical count, 0..V_TOTAL-1
// line_start   out  1   high for the single cycle where x==0
// frame_start  out  1   high for the single cycle where x==0 && y==0
// visible      out  1   (x<H_VISIBLE && y<V_VISIBLE), delayed SYNC_DELAY cycles
// hsync        out  1   active-low; delayed SYNC_DELAY cycles
// vsync        out  1   active-low; delayed SYNC_DELAY cycles
//
// BEHAVIOUR
// - H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL=V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
// - x, y, line_start and frame_start are registers; all undelayed.
// - Per clock:
//   - x increments; at x==H_TOTAL-1 it wraps to 0 and y increments.
//   - y wraps H_TOTAL-1/V_TOTAL-1 -> 0/0 on the same edge.
// - Undelayed decode of the current (x,y):
//   - visible when x<H_VISIBLE && y<V_VISIBLE.
//   - hsync=0 when H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751).
//   - vsync=0 when V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491), for whole lines.
// - Output alignment:
//   - SYNC_DELAY=0: output visible/hsync/vsync equal the decode for the same cycle's x,y.
//   - SYNC_DELAY=N: outputs equal the decode of the (x,y) presented N cycles earlier (shift register).
// - Reset (async assert, takes effect immediately):
//   - x=H_TOTAL-1, y=V_TOTAL-1.
//   - line_start=0, frame_start=0, visible=0, hsync=1, vsync=1.
//   - Every delay-stage register = {visible 0, hsync 1, vsync 1}.
// - First rising edge after rst deasserts: x=0, y=0, line_start=1, frame_start=1.
//   Undelayed decode reports visible=1.
// - Reset asserted mid-frame: state and pipeline restart exactly as above; no partial pulses are
//   emitted afterwards. Any sync pulse in progress ends immediately (hsync/vsync go 1).
// - Widths: H_TOTAL and V_TOTAL must each be <= 1024; elaboration error otherwise.
// - All outputs are glitch-free registers; no combinational path from inputs to outputs.
//
// TESTING
// 1. Hold rst 5 cycles -> x=799, y=524, hsync=1, vsync=1, visible=0, strobes 0.
//    First edge after release -> x=0, y=0, frame_start=1.
// 2. Run 8 frames -> each frame_start exactly 420000 cycles apart.
//    line_start every 800 cycles; 525 line_starts per frame.
// 3. Each line -> hsync low for exactly 96 cycles, falling 656 cycles after line_start.
//    Each frame -> vsync low for exactly 1600 cycles, falling at x=0, y=490.
// 4. Count visible per frame -> 307200.
//    visible=1 at (0,0) and (639,479); visible=0 at (640,0) and (0,480).
// 5. Assert rst at x=700, y=490 (inside vsync) -> hsync=1 and vsync=1 at once.
//    After release -> next frame_start after 1 cycle, then every 420000 cycles.
// 6. SYNC_DELAY=2 -> hsync falls when x==658, visible falls when x==642.
//    After reset release, visible=0 for the first 2 cycles, then 1.

Source files
------------

// File: rtl/vga_timing.sv
// Raster timing generator: free-running x/y counters with registered line/frame strobes
// and visible/hsync/vsync decode, optionally re-timed through a SYNC_DELAY-deep shift register.
module vga_timing #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 0
) (
    input  logic       clk_25_175,
    input  logic       rst,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       visible,
    output logic       hsync,
    output logic       vsync
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEG  = H_VISIBLE + H_FRONT;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_VISIBLE + V_FRONT;
    localparam int VS_END  = VS_BEG + V_SYNC;

    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{visible: 1'b0, hsync: 1'b1, vsync: 1'b1};

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_size
            $error("vga_timing: H_TOTAL and V_TOTAL must each be <= 1024");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
            $error("vga_timing: SYNC_DELAY must be in 0..7");
        end
    endgenerate

    logic [9:0]             nx, ny;
    sync_t                  dec;
    sync_t [SYNC_DELAY:0]   pipe;

    always_comb begin
        nx = x + 10'd1;
        ny = y;
        if (x == 10'(H_TOTAL - 1)) begin
            nx = '0;
            ny = (y == 10'(V_TOTAL - 1)) ? '0 : y + 10'd1;
        end
    end

    // Decode the coordinates about to be loaded so stage 0 lines up with x/y without
    // a combinational path to the outputs.
    always_comb begin
        dec         = SYNC_IDLE;
        dec.visible = (int'(nx) < H_VISIBLE) && (int'(ny) < V_VISIBLE);
        dec.hsync   = !((int'(nx) >= HS_BEG) && (int'(nx) < HS_END));
        dec.vsync   = !((int'(ny) >= VS_BEG) && (int'(ny) < VS_END));
    end

    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            x           <= 10'(H_TOTAL - 1);
            y           <= 10'(V_TOTAL - 1);
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            for (int i = 0; i <= SYNC_DELAY; i++) pipe[i] <= SYNC_IDLE;
        end else begin
            x           <= nx;
            y           <= ny;
            line_start  <= (nx == '0);
            frame_start <= (nx == '0) && (ny == '0);
            pipe[0]     <= dec;
            for (int i = 1; i <= SYNC_DELAY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign visible = pipe[SYNC_DELAY].visible;
    assign hsync   = pipe[SYNC_DELAY].hsync;
    assign vsync   = pipe[SYNC_DELAY].vsync;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default-size instances for first-line timing, shrunken-raster
// instances for whole-frame behaviour; all checked against a cycle-count reference model.
module tb_vga_timing;
    localparam int SHV = 20, SHF = 3, SHS = 5, SHB = 4;
    localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;
    localparam int SF  = SHT * SVT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y, e_x, e_y;
    logic a_ls, a_fs, a_vis, a_hs, a_vs;
    logic b_ls, b_fs, b_vis, b_hs, b_vs;
    logic c_ls, c_fs, c_vis, c_hs, c_vs;
    logic e_ls, e_fs, e_vis, e_hs, e_vs;

    vga_timing u_def (.clk_25_175(clk), .rst(rst), .x(a_x), .y(a_y), .line_start(a_ls),
        .frame_start(a_fs), .visible(a_vis), .hsync(a_hs), .vsync(a_vs));
    vga_timing #(.SYNC_DELAY(2)) u_dly (.clk_25_175(clk), .rst(rst), .x(b_x), .y(b_y),
        .line_start(b_ls), .frame_start(b_fs), .visible(b_vis), .hsync(b_hs), .vsync(b_vs));
    vga_timing #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_DELAY(0))
        u_sm (.clk_25_175(clk), .rst(rst), .x(c_x), .y(c_y), .line_start(c_ls),
        .frame_start(c_fs), .visible(c_vis), .hsync(c_hs), .vsync(c_vs));
    vga_timing #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_DELAY(3))
        u_smd (.clk_25_175(clk), .rst(rst), .x(e_x), .y(e_y), .line_start(e_ls),
        .frame_start(e_fs), .visible(e_vis), .hsync(e_hs), .vsync(e_vs));

    typedef struct packed {
        logic [9:0] x, y;
        logic ls, fs, vis, hs, vs;
    } obs_t;

    typedef struct {
        int k;
        logic [9:0] x, y;
        logic ls, fs, vis, hs, dvis, dhs;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int k = 0;   // rising edges since reset release

    // Expected outputs purely from the edge count: position p = (k-1) mod frame length.
    function automatic obs_t ref_out(int hv, int hf, int hsw, int hb, int vv, int vf,
                                     int vsw, int vb, int nd, int kk);
        obs_t r;
        int ht = hv + hf + hsw + hb;
        int vt = vv + vf + vsw + vb;
        int f  = ht * vt;
        int p  = (kk + f - 1) % f;
        int q, xx, yy;
        r.x  = 10'(p % ht);
        r.y  = 10'(p / ht);
        r.ls = (kk > 0) && (p % ht == 0);
        r.fs = (kk > 0) && (p == 0);
        if (kk - nd <= 0) begin
            r.vis = 1'b0; r.hs = 1'b1; r.vs = 1'b1;
        end else begin
            q  = (kk - nd - 1) % f;
            xx = q % ht;
            yy = q / ht;
            r.vis = (xx < hv) && (yy < vv);
            r.hs  = !((xx >= hv + hf) && (xx < hv + hf + hsw));
            r.vs  = !((yy >= vv + vf) && (yy < vv + vf + vsw));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (k=%0d)", name, act, expv, k);
        end
    endtask

    task automatic check_all();
        chk("def", 32'({a_x, a_y, a_ls, a_fs, a_vis, a_hs, a_vs}),
            32'(ref_out(640, 16, 96, 48, 480, 10, 2, 33, 0, k)));
        chk("dly", 32'({b_x, b_y, b_ls, b_fs, b_vis, b_hs, b_vs}),
            32'(ref_out(640, 16, 96, 48, 480, 10, 2, 33, 2, k)));
        chk("sm", 32'({c_x, c_y, c_ls, c_fs, c_vis, c_hs, c_vs}),
            32'(ref_out(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 0, k)));
        chk("smd", 32'({e_x, e_y, e_ls, e_fs, e_vis, e_hs, e_vs}),
            32'(ref_out(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 3, k)));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) k++;
        #1;
        check_all();
    endtask

    function automatic vec_t mkv(int kk, int xx, int yy, bit ls, bit fs, bit vis, bit hs,
                                 bit dvis, bit dhs);
        vec_t v;
        v.k = kk; v.x = 10'(xx); v.y = 10'(yy);
        v.ls = ls; v.fs = fs; v.vis = vis; v.hs = hs; v.dvis = dvis; v.dhs = dhs;
        return v;
    endfunction

    vec_t tbl [16];

    initial begin
        int n, vis_n, ls_n, hl_n, vl_n, fs_n;
        //          k    x    y  ls fs vis hs dvis dhs
        tbl[0]  = mkv(0,   799, 524, 0, 0, 0, 1, 0, 1);
        tbl[1]  = mkv(1,   0,   0,   1, 1, 1, 1, 0, 1);
        tbl[2]  = mkv(2,   1,   0,   0, 0, 1, 1, 0, 1);
        tbl[3]  = mkv(3,   2,   0,   0, 0, 1, 1, 1, 1);
        tbl[4]  = mkv(640, 639, 0,   0, 0, 1, 1, 1, 1);
        tbl[5]  = mkv(641, 640, 0,   0, 0, 0, 1, 1, 1);
        tbl[6]  = mkv(642, 641, 0,   0, 0, 0, 1, 1, 1);
        tbl[7]  = mkv(643, 642, 0,   0, 0, 0, 1, 0, 1);
        tbl[8]  = mkv(657, 656, 0,   0, 0, 0, 0, 0, 1);
        tbl[9]  = mkv(659, 658, 0,   0, 0, 0, 0, 0, 0);
        tbl[10] = mkv(752, 751, 0,   0, 0, 0, 0, 0, 0);
        tbl[11] = mkv(753, 752, 0,   0, 0, 0, 1, 0, 0);
        tbl[12] = mkv(755, 754, 0,   0, 0, 0, 1, 0, 1);
        tbl[13] = mkv(800, 799, 0,   0, 0, 0, 1, 0, 1);
        tbl[14] = mkv(801, 0,   1,   1, 0, 1, 1, 0, 1);
        tbl[15] = mkv(803, 2,   1,   0, 0, 1, 1, 1, 1);

        // Reset held for 5 cycles, then the first line of the default raster.
        repeat (5) tick();
        for (int i = 0; i < 16; i++) begin
            while (k < tbl[i].k) tick();
            chk("tbl_def", 32'({a_x, a_y, a_ls, a_fs, a_vis, a_hs, a_vs}),
                32'({tbl[i].x, tbl[i].y, tbl[i].ls, tbl[i].fs, tbl[i].vis, tbl[i].hs, 1'b1}));
            chk("tbl_dly", 32'({b_vis, b_hs}), 32'({tbl[i].dvis, tbl[i].dhs}));
            if (rst) begin
                @(negedge clk);
                rst = 1'b0;
            end
        end

        // Eight whole frames of the small raster: period and per-frame pulse totals.
        n = 0;
        while (!c_fs && n < 2 * SF) begin tick(); n++; end
        chk("sm_fs_found", 32'(c_fs), 32'd1);
        for (int f = 0; f < 8; f++) begin
            vis_n = 0; ls_n = 0; hl_n = 0; vl_n = 0; fs_n = 0;
            for (int c = 0; c < SF; c++) begin
                vis_n += int'(c_vis); ls_n += int'(c_ls); fs_n += int'(c_fs);
                hl_n += int'(!c_hs);  vl_n += int'(!c_vs);
                tick();
            end
            chk("sm_period", 32'(c_fs), 32'd1);
            chk("sm_fs_count", fs_n, 1);
            chk("sm_visible_count", vis_n, SHV * SVV);
            chk("sm_line_count", ls_n, SVT);
            chk("sm_hsync_low", hl_n, SHS * SVT);
            chk("sm_vsync_low", vl_n, SVS * SHT);
        end

        // Reset landing inside both sync pulses.
        n = 0;
        while (!(c_y == 10'(SVV + SVF) && c_x == 10'(SHV + SHF + 2)) && n < 2 * SF) begin
            tick(); n++;
        end
        chk("mid_pre_sync", 32'({c_hs, c_vs}), 32'b00);
        #2 rst = 1'b1;
        k = 0;
        #1;
        chk("mid_async", 32'({c_hs, c_vs, c_vis, c_ls, c_fs}), 32'b11000);
        check_all();
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("mid_first_fs", 32'(c_fs), 32'd1);
        n = 0;
        do begin tick(); n++; end while (!c_fs && n < 2 * SF);
        chk("mid_period", n, SF);

        // Random run lengths interrupted by asynchronous resets.
        for (int it = 0; it < 20; it++) begin
            repeat ($urandom_range(1, 1500)) tick();
            #($urandom_range(1, 3)) rst = 1'b1;
            k = 0;
            #1;
            check_all();
            repeat ($urandom_range(1, 4)) tick();
            @(negedge clk);
            rst = 1'b0;
        end
        repeat (SF + 10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
